// File: rtl/seq_audio.sv
// rtl/seq_audio.sv - multi-voice beat sequencer and square-wave tone generator for PMOD audio
//
// Purpose:
//   Steps through a song held in an external synchronous ROM, one beat every
//   BEAT_CYCLES clocks (one FETCH cycle plus BEAT_CYCLES-1 RUN cycles). It
//   produces one square wave per voice, with a half-period taken from that
//   voice's ROM field. A half-period of zero is a rest. The design supports
//   pause/resume, restart, a programmable song length, looping and a done pulse.
//
// Optional feature macro: SEQ_AUDIO_MIX_EN
//   When defined, the module adds a pwm_mix output. It is a round-robin
//   time-multiplexed mix of all voices and lags pwm by one cycle.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   play       in   level: 1 = run, 0 = pause/stop
//   loop       in   level: sampled at the end of the last beat
//   restart    in   single-cycle pulse: jump back to beat 0
//   song_last  in   [ADDR_W]  address of the final beat
//   beat_addr  out  [ADDR_W]  song ROM address (registered)
//   note_data  in   [CHANNELS*NOTE_W]  ROM data; voice i at [i*NOTE_W +: NOTE_W]
//   pwm        out  [CHANNELS]  square-wave tone per voice
//   pmod_gain  out  constant 1 (6 dB gain)
//   amp_en     out  amplifier shutdown_n; high in FETCH/RUN/PAUSE
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse when a non-looping song ends
//   pwm_mix    out  (SEQ_AUDIO_MIX_EN only) voice mix, one cycle late

module seq_audio #(
  parameter int CHANNELS    = 2,
  parameter int NOTE_W      = 20,
  parameter int ADDR_W      = 8,
  parameter int BEAT_CYCLES = 12500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         play,
  input  logic                         loop,
  input  logic                         restart,
  input  logic [ADDR_W-1:0]            song_last,
  output logic [ADDR_W-1:0]            beat_addr,
  input  logic [CHANNELS*NOTE_W-1:0]   note_data,
  output logic [CHANNELS-1:0]          pwm,
  output logic                         pmod_gain,
  output logic                         amp_en,
  output logic                         busy,
  output logic                         done
`ifdef SEQ_AUDIO_MIX_EN
  ,
  output logic                         pwm_mix
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int BCNT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  // The RUN phase covers counts 0..BEAT_CYCLES-2. With the single FETCH
  // cycle added, each beat is exactly BEAT_CYCLES clocks long.
  localparam logic [BCNT_W-1:0] BEAT_END = BCNT_W'(BEAT_CYCLES - 2);

  logic [2:0]          state_q;
  logic [2:0]          state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                done_nxt;
  logic [BCNT_W-1:0]   beat_cnt_q;
  logic                beat_end;
  logic                load_notes;
  logic                run_adv;
  logic [CHANNELS-1:0] tone_q;

  assign beat_end = (beat_cnt_q == BEAT_END);

  // Next-state logic. A restart pulse overrides everything else outside
  // IDLE. A pause request inside RUN takes precedence over end-of-beat.
  always_comb begin
    state_nxt = state_q;
    addr_nxt  = beat_addr;
    done_nxt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_nxt = S_FETCH;
          addr_nxt  = '0;
        end
      end
      S_FETCH: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!play) begin
          state_nxt = S_PAUSE;
        end else if (beat_end) begin
          // Equality only: if song_last drops below beat_addr mid-song,
          // the address wraps through 2^ADDR_W and play continues.
          if (beat_addr == song_last) begin
            if (loop) begin
              state_nxt = S_FETCH;
              addr_nxt  = '0;
            end else begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end
          end else begin
            state_nxt = S_FETCH;
            addr_nxt  = beat_addr + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (play) begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (!play) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        addr_nxt  = '0;
      end
    endcase

    if (restart && (state_q != S_IDLE)) begin
      addr_nxt  = '0;
      state_nxt = play ? S_FETCH : S_IDLE;
      done_nxt  = 1'b0;
    end
  end

  // Notes are captured only on the FETCH->RUN edge. The beat and tone
  // counters advance only while RUN continues into RUN, so the cycle
  // that leaves for PAUSE leaves both counters frozen.
  assign load_notes = (state_q == S_FETCH) && (state_nxt == S_RUN);
  assign run_adv    = (state_q == S_RUN)   && (state_nxt == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_addr <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      beat_addr <= addr_nxt;
      done      <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (load_notes) begin
      beat_cnt_q <= '0;
    end else if (run_adv) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  for (genvar v = 0; v < CHANNELS; v++) begin : g_voice
    logic [NOTE_W-1:0] half_q;
    logic [NOTE_W-1:0] tcnt_q;
    logic              lvl_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        half_q <= '0;
        tcnt_q <= '0;
        lvl_q  <= 1'b0;
      end else if (load_notes) begin
        half_q <= note_data[v*NOTE_W +: NOTE_W];
        tcnt_q <= '0;
        lvl_q  <= 1'b0;
      end else if (run_adv) begin
        if (half_q == '0) begin
          // Rest: keep the voice silent.
          tcnt_q <= '0;
          lvl_q  <= 1'b0;
        end else if (tcnt_q == half_q - 1'b1) begin
          tcnt_q <= '0;
          lvl_q  <= ~lvl_q;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end
    end

    assign tone_q[v] = lvl_q;
  end

  // The tone phase is kept through a pause, but the output is only driven
  // while RUN is active.
  assign pwm       = tone_q & {CHANNELS{state_q == S_RUN}};
  assign pmod_gain = 1'b1;
  assign amp_en    = (state_q == S_FETCH) || (state_q == S_RUN) ||
                     (state_q == S_PAUSE);
  assign busy      = (state_q != S_IDLE);

`ifdef SEQ_AUDIO_MIX_EN
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [SEL_W-1:0] sel_q;
  logic             mix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      mix_q <= 1'b0;
    end else begin
      sel_q <= (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
      mix_q <= pwm[sel_q];
    end
  end

  // The registered sample is still shown in the FETCH cycle that follows
  // RUN, which preserves the one-cycle lag across beat boundaries.
  assign pwm_mix = mix_q & ((state_q == S_RUN) || (state_q == S_FETCH));
`endif

endmodule

// File: tb/tb_seq_audio.sv
// tb/tb_seq_audio.sv - directed self-checking bench for seq_audio
module tb_seq_audio;

  localparam int CHANNELS    = 2;
  localparam int NOTE_W      = 20;
  localparam int ADDR_W      = 8;
  localparam int BEAT_CYCLES = 16;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       play = 1'b0;
  logic                       loop = 1'b0;
  logic                       restart = 1'b0;
  logic [ADDR_W-1:0]          song_last = 8'd3;
  logic [ADDR_W-1:0]          beat_addr;
  logic [CHANNELS*NOTE_W-1:0] note_data = '0;
  logic [CHANNELS-1:0]        pwm;
  logic                       pmod_gain;
  logic                       amp_en;
  logic                       busy;
  logic                       done;
`ifdef SEQ_AUDIO_MIX_EN
  logic                       pwm_mix;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Synchronous song ROM: voice0 half=4, voice1 rest, on every beat.
  logic [CHANNELS*NOTE_W-1:0] rom [4];
  initial begin
    for (int i = 0; i < 4; i++) rom[i] = {20'd0, 20'd4};
  end
  always @(posedge clk) note_data <= rom[beat_addr[1:0]];

  seq_audio #(
    .CHANNELS(CHANNELS), .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .BEAT_CYCLES(BEAT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .loop(loop), .restart(restart),
    .song_last(song_last), .beat_addr(beat_addr), .note_data(note_data),
    .pwm(pwm), .pmod_gain(pmod_gain), .amp_en(amp_en), .busy(busy), .done(done)
`ifdef SEQ_AUDIO_MIX_EN
    , .pwm_mix(pwm_mix)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    play = 1'b0; loop = 1'b0; restart = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Expected pwm[0] at sample n, counting from the first edge that sees play=1.
  function automatic logic exp_pwm0(int n);
    int pos = (n - 1) % 16;
    if (pos == 0) return 1'b0;
    return (((pos - 1) / 4) % 2) == 1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick();
    checks++;
    if ({beat_addr, pwm, amp_en, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%0d pwm=%b amp_en=%b busy=%b done=%b, want all 0",
               beat_addr, pwm, amp_en, busy, done);
    end
    checks++;
    if (pmod_gain !== 1'b1) begin
      failures++;
      $display("FAIL pmod_gain: got %b want 1", pmod_gain);
    end
  endtask

  task automatic test_basic_play;
    do_reset();
    play = 1'b1;
    for (int n = 1; n <= 67; n++) begin
      tick();
      if (n <= 64) begin
        checks++;
        if (beat_addr !== ADDR_W'((n - 1) / 16)) begin
          failures++;
          $display("FAIL basic_addr n=%0d: got %0d want %0d", n, beat_addr, (n - 1) / 16);
        end
        checks++;
        if (pwm !== {1'b0, exp_pwm0(n)}) begin
          failures++;
          $display("FAIL basic_pwm n=%0d: got %b want %b", n, pwm, {1'b0, exp_pwm0(n)});
        end
        checks++;
        if (done !== 1'b0 || amp_en !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL basic_status n=%0d: got done=%b amp_en=%b busy=%b want 0,1,1",
                   n, done, amp_en, busy);
        end
      end else if (n == 65) begin
        checks++;
        if (done !== 1'b1 || amp_en !== 1'b0 || pwm !== 2'b00 || beat_addr !== 8'd3) begin
          failures++;
          $display("FAIL basic_done: got done=%b amp_en=%b pwm=%b addr=%0d want 1,0,00,3",
                   done, amp_en, pwm, beat_addr);
        end
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || amp_en !== 1'b0) begin
          failures++;
          $display("FAIL basic_done_pulse n=%0d: got done=%b busy=%b amp_en=%b want 0,1,0",
                   n, done, busy, amp_en);
        end
      end
    end
    play = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_to_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_loop;
    do_reset();
    loop = 1'b1;
    play = 1'b1;
    for (int n = 1; n <= 84; n++) begin
      tick();
      checks++;
      if (beat_addr !== ADDR_W'(((n - 1) / 16) % 4) || done !== 1'b0) begin
        failures++;
        $display("FAIL loop n=%0d: got addr=%0d done=%b want %0d,0",
                 n, beat_addr, done, ((n - 1) / 16) % 4);
      end
    end
    checks++;
    if (pwm[0] !== exp_pwm0(84)) begin
      failures++;
      $display("FAIL loop_pwm: got %b want %b", pwm[0], exp_pwm0(84));
    end
    loop = 1'b0;
  endtask

  task automatic test_pause_resume;
    do_reset();
    play = 1'b1;
    for (int n = 1; n <= 22; n++) tick();
    play = 1'b0;          // sampled in the beat-1 cycle with count 4
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (pwm !== 2'b00 || beat_addr !== 8'd1 || busy !== 1'b1 || amp_en !== 1'b1) begin
        failures++;
        $display("FAIL pause k=%0d: got pwm=%b addr=%0d busy=%b amp_en=%b want 00,1,1,1",
                 k, pwm, beat_addr, busy, amp_en);
      end
    end
    play = 1'b1;
    tick();
    checks++;
    if (pwm !== 2'b01) begin
      failures++;
      $display("FAIL resume_phase: got pwm=%b want 01", pwm);
    end
    for (int k = 1; k < 11; k++) tick();
    checks++;
    if (beat_addr !== 8'd1) begin
      failures++;
      $display("FAIL resume_last_run: got addr=%0d want 1", beat_addr);
    end
    tick();
    checks++;
    if (beat_addr !== 8'd2 || pwm !== 2'b00) begin
      failures++;
      $display("FAIL resume_beat_end: got addr=%0d pwm=%b want 2,00", beat_addr, pwm);
    end
  endtask

  task automatic test_restart_priority;
    do_reset();
    play = 1'b1;
    for (int n = 1; n <= 36; n++) tick();
    checks++;
    if (beat_addr !== 8'd2) begin
      failures++;
      $display("FAIL restart_pre: got addr=%0d want 2", beat_addr);
    end
    restart = 1'b1;
    play = 1'b0;
    tick();
    restart = 1'b0;
    checks++;
    if (busy !== 1'b0 || beat_addr !== 8'd0 || amp_en !== 1'b0 || pwm !== 2'b00) begin
      failures++;
      $display("FAIL restart_idle: got busy=%b addr=%0d amp_en=%b pwm=%b want 0,0,0,00",
               busy, beat_addr, amp_en, pwm);
    end
    play = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || beat_addr !== 8'd0) begin
      failures++;
      $display("FAIL restart_replay: got busy=%b addr=%0d want 1,0", busy, beat_addr);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    play = 1'b1;
    for (int n = 1; n <= 38; n++) tick();
    checks++;
    if (pwm !== 2'b01 || beat_addr !== 8'd2) begin
      failures++;
      $display("FAIL async_pre: got pwm=%b addr=%0d want 01,2", pwm, beat_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({beat_addr, pwm, amp_en, busy, done} !== '0) begin
      failures++;
      $display("FAIL async_reset: got addr=%0d pwm=%b amp_en=%b busy=%b done=%b want all 0",
               beat_addr, pwm, amp_en, busy, done);
    end
    play = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_play();
    test_loop();
    test_pause_resume();
    test_restart_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
